muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/addsub33.sv | 14 +
 rtl/muldiv_seq.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the M-extension sequential multiply/divide unit.
// Holds the OP opcode / MULDIV funct7 encodings, the funct3 op codes, the
// muldiv FSM state enum and small decode helpers used by muldiv_seq.
package riscv_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // funct3[2] splits the M-extension into multiply (0) and divide (1).
  function automatic logic f3_is_div(input logic [2:0] f);
    return f[2];
  endfunction

  // Operand A is treated as signed for MULH, MULHSU, DIV, REM.
  // MUL is unsigned here: its low 32 product bits do not depend on signedness.
  function automatic logic f3_a_signed(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
  endfunction

  // Operand B is treated as signed for MULH, DIV, REM.
  function automatic logic f3_b_signed(input logic [2:0] f);
    return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
  endfunction

endpackage

// File: rtl/addsub33.sv
// 33-bit adder/subtractor shared by the multiply and divide iterations.
//   a_i, b_i : operands
//   sub_i    : 1 -> a_i - b_i, 0 -> a_i + b_i
//   sum_o    : 33-bit result (carry-out discarded)
module addsub33 (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  input  logic        sub_i,
  output logic [32:0] sum_o
);

  assign sum_o = a_i + (b_i ^ {33{sub_i}}) + {32'd0, sub_i};

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over
// 32 iterations, both on magnitudes with a final sign fix-up.
// Divide-by-zero and signed overflow bypass the iteration entirely.
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_valid/i_funct3        : request and M-extension op code
//   i_rs1_data/i_rs2_data   : operand A / operand B
//   i_flush                 : abort anything in flight, back to IDLE
//   i_ack                   : consumer takes the result
//   o_ready/o_busy/o_valid  : IDLE / CALC or DONE / DONE
//   o_result                : 32-bit result, held while o_valid
module muldiv_seq
  import riscv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_flush,
  input  logic        i_ack,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result
);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;     // |A| for multiply, |B| for divide
  logic [63:0] acc_q, acc_d;       // mul: {hi, multiplier}; div: {rem, quotient}
  logic        neg_q, neg_d;       // final result needs negation
  logic [31:0] result_q, result_d;

  // ---------------- request decode ----------------
  logic        accept;
  logic        a_sgn, b_sgn;
  logic [31:0] a_mag, b_mag;
  logic        div_req, div_zero, div_ovf, special;
  logic [31:0] special_res;

  assign accept   = i_valid && (state_q == ST_IDLE) && !i_flush;
  assign a_sgn    = f3_a_signed(i_funct3) && i_rs1_data[31];
  assign b_sgn    = f3_b_signed(i_funct3) && i_rs2_data[31];
  assign a_mag    = a_sgn ? (32'd0 - i_rs1_data) : i_rs1_data;
  assign b_mag    = b_sgn ? (32'd0 - i_rs2_data) : i_rs2_data;
  assign div_req  = f3_is_div(i_funct3);
  assign div_zero = div_req && (i_rs2_data == 32'd0);
  // Only the signed divide ops (DIV, REM) have funct3[0] == 0.
  assign div_ovf  = div_req && !i_funct3[0] &&
                    (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
  assign special  = div_zero || div_ovf;

  // funct3[1] picks the remainder flavour of a divide.
  always_comb begin
    special_res = 32'd0;
    if (div_zero)     special_res = i_funct3[1] ? i_rs1_data : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // ---------------- shared adder + one iteration ----------------
  logic [32:0] as_a, as_b, as_sum;
  logic        as_sub;
  logic        div_ge;
  logic [63:0] iter_acc;

  // Divide works on {rem, next dividend bit}; multiply adds |A| into the upper half.
  assign as_sub = f3_is_div(op_q);
  assign as_a   = as_sub ? {acc_q[63:32], acc_q[31]} : {1'b0, acc_q[63:32]};
  assign as_b   = {1'b0, opnd_q};

  addsub33 u_addsub (
    .a_i   (as_a),
    .b_i   (as_b),
    .sub_i (as_sub),
    .sum_o (as_sum)
  );

  // Partial remainder stays below the divisor, so bit 32 of the 33-bit
  // difference is a reliable borrow flag.
  assign div_ge = !as_sum[32];

  always_comb begin
    if (as_sub)
      iter_acc = {(div_ge ? as_sum[31:0] : as_a[31:0]), acc_q[30:0], div_ge};
    else
      iter_acc = {(acc_q[0] ? as_sum : {1'b0, acc_q[63:32]}), acc_q[31:1]};
  end

  // Sign fix-up and result selection from the last iteration's value.
  logic [63:0] prod_fix;
  logic [31:0] div_sel, fin_res;

  always_comb begin
    prod_fix = neg_q ? (64'd0 - iter_acc) : iter_acc;
    div_sel  = op_q[1] ? iter_acc[63:32] : iter_acc[31:0];
    if (f3_is_div(op_q))
      fin_res = neg_q ? (32'd0 - div_sel) : div_sel;
    else
      fin_res = (op_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == 5'd0) state_d = ST_DONE;
        ST_DONE: if (i_ack) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready  = (state_q == ST_IDLE);
    o_busy   = (state_q == ST_CALC) || (state_q == ST_DONE);
    o_valid  = (state_q == ST_DONE);
    o_result = result_q;
  end

  // ---------------- datapath ----------------
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (i_flush) begin
      cnt_d    = 5'd0;
      op_d     = 3'd0;
      opnd_d   = 32'd0;
      acc_d    = 64'd0;
      neg_d    = 1'b0;
      result_d = 32'd0;
    end else if (accept) begin
      op_d   = i_funct3;
      cnt_d  = 5'd31;
      opnd_d = div_req ? b_mag : a_mag;
      acc_d  = {32'd0, (div_req ? a_mag : b_mag)};
      // Remainder follows the dividend; everything else follows sign(A)^sign(B).
      neg_d  = (i_funct3 == F3_REM) ? a_sgn : (a_sgn ^ b_sgn);
      if (special) result_d = special_res;
    end else if (state_q == ST_CALC) begin
      acc_d = iter_acc;
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd0) result_d = fin_res;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized
// ops checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

  logic        i_clk, i_rst_n, i_valid, i_flush, i_ack;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic        o_ready, o_busy, o_valid;
  logic [31:0] o_result;

  int n_vec = 0;
  int n_err = 0;

  muldiv_seq dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_flush    (i_flush),
    .i_ack      (i_ack),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the M-extension definitions.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb, sr;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    sr  = 32'sd0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sr = sa / sb; return sr;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        sr = sa % sb; return sr;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Wait (bounded) for IDLE, issue a request, measure latency, check result,
  // hold off ack for 'hold' cycles, then ack (optionally with i_valid high).
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit vack);
    logic [31:0] exp;
    int k;
    exp = model(f, a, b);
    k = 0;
    while (!o_ready && k < 100) begin @(negedge i_clk); k++; end
    check("ready_before_req", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1; i_funct3 = f; i_rs1_data = a; i_rs2_data = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_funct3 = 3'($urandom); i_rs1_data = $urandom; i_rs2_data = $urandom;
    k = 0;
    while (1) begin
      @(negedge i_clk); k++;
      if (o_valid || k >= 40) break;
    end
    check($sformatf("latency f3=%0d", f), 32'(k), 32'(exp_lat(f, a, b)));
    check($sformatf("result f3=%0d a=%h b=%h", f, a, b), o_result, exp);
    check("busy_in_done", {31'd0, o_busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      check("hold_result", o_result, exp);
      check("hold_ready_low", {31'd0, o_ready}, 32'd0);
      check("hold_valid", {31'd0, o_valid}, 32'd1);
    end
    i_ack = 1'b1;
    if (vack) begin i_valid = 1'b1; i_funct3 = 3'd0; i_rs1_data = 32'd2; i_rs2_data = 32'd2; end
    @(posedge i_clk); #1;
    i_ack = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    check("ready_after_ack", {31'd0, o_ready}, 32'd1);
    check("idle_after_ack", {30'd0, o_busy, o_valid}, 32'd0);
  endtask

  initial begin
    int k, seen;
    logic [2:0] f;
    logic [31:0] a, b;
    i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ack = 1'b0;
    i_funct3 = 3'd0; i_rs1_data = 32'd0; i_rs2_data = 32'd0;
    #3;
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_busy_valid", {30'd0, o_busy, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    @(negedge i_clk); @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed cases
    do_op(3'd0, 32'd7, 32'd6, 0, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    do_op(3'd5, 32'd100, 32'd7, 0, 1'b0);
    do_op(3'd5, 32'd5, 32'd0, 0, 1'b0);
    do_op(3'd7, 32'd5, 32'd0, 0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    // ack held low 5 cycles; request offered with ack must be ignored
    do_op(3'd0, 32'd1234, 32'd5678, 5, 1'b1);

    // Flush mid-CALC with i_valid high
    i_valid = 1'b1; i_funct3 = 3'd0; i_rs1_data = 32'd11; i_rs2_data = 32'd13;
    @(posedge i_clk); #1; i_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    i_flush = 1'b1; i_valid = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    check("flush_ready", {31'd0, o_ready}, 32'd1);
    check("flush_busy_valid", {30'd0, o_busy, o_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge i_clk); if (o_valid || o_busy) seen++; end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Flush in IDLE overrides a request
    i_flush = 1'b1; i_valid = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    check("flush_idle_no_accept", {30'd0, o_busy, o_ready}, 32'd1);

    // Flush in DONE drops o_valid
    i_valid = 1'b1; i_funct3 = 3'd5; i_rs1_data = 32'd9; i_rs2_data = 32'd0;
    @(posedge i_clk); #1; i_valid = 1'b0;
    @(negedge i_clk);
    check("done_before_flush", {31'd0, o_valid}, 32'd1);
    i_flush = 1'b1; i_ack = 1'b1;
    @(posedge i_clk); #1; i_flush = 1'b0; i_ack = 1'b0;
    @(negedge i_clk);
    check("flush_done_valid", {30'd0, o_valid, o_ready}, 32'd1);

    // Asynchronous reset mid-CALC
    i_valid = 1'b1; i_funct3 = 3'd0; i_rs1_data = 32'd99; i_rs2_data = 32'd77;
    @(posedge i_clk); #1; i_valid = 1'b0;
    repeat (10) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_ready", {31'd0, o_ready}, 32'd1);
    check("arst_busy_valid", {30'd0, o_busy, o_valid}, 32'd0);
    check("arst_result", o_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_op(3'd0, 32'd3, 32'd3, 0, 1'b0);

    // Randomized ops, biased toward the bypass and small-divisor corners
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 7);
      if (k == 0) b = 32'd0;
      else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (k == 2) b = 32'($urandom_range(1, 15));
      else if (k == 3) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      do_op(f, a, b, $urandom_range(0, 2), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
